// File: rtl/host_specific_top_rx_from_host.sv
// Host-side receive front end: captures one host command packet, validates and
// decodes it, tracks the link encryption-enable state, builds a 128-bit frame
// (optionally XOR-encrypted) and emits it as two SECDED Hamming(72,64) codewords.
module host_specific_top_rx_from_host #(
  parameter logic [7:0]   OP_ENCRYPT  = 8'h01,
  parameter logic [7:0]   OP_READ_YAW = 8'h03,
  parameter logic [47:0]  BROADCAST   = 48'hFFFF_FFFF_FFFF,
  parameter logic [111:0] ENC_KEY     = {14{8'h5A}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1023:0] input_data,
  input  logic          send_packet,
  output logic [143:0]  encoded_output,
  output logic          error,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ENCODE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic          capture_s;
  logic          decode_s;
  logic          finish_s;
  logic [71:0]   pkt_r;
  logic          valid_r;
  logic          encrypt_en_r;
  logic [7:0]    seq_r;
  logic [7:0]    opcode_s;
  logic [47:0]   target_s;
  logic [7:0]    size_s;
  logic [7:0]    payload_s;
  logic          valid_s;
  logic          new_en_s;
  logic [63:0]   w0_s;
  logic [63:0]   w1_s;
  logic [111:0]  mix_s;
  logic          unused_bits_s;

  // Only the first nine bytes of the packet carry meaning.
  assign unused_bits_s = ^input_data[1023:72];

  // Hamming(72,64) SECDED: parity at power-of-two positions, data fills the
  // remaining positions 3..71 ascending, overall parity in bit 0.
  function automatic logic [71:0] secded_encode(input logic [63:0] data);
    logic [71:0] cw;
    logic [5:0]  j;
    logic        par;
    cw = 72'd0;
    j  = 6'd0;
    for (logic [6:0] p = 7'd1; p < 7'd72; p++) begin
      if ((p & (p - 7'd1)) != 7'd0) begin
        cw[p] = data[j];
        j     = j + 6'd1;
      end else begin
        cw[p] = 1'b0;
      end
    end
    for (logic [2:0] k = 3'd0; k < 3'd7; k++) begin
      par = 1'b0;
      for (logic [6:0] p = 7'd1; p < 7'd72; p++) begin
        if (p[k]) begin
          par = par ^ cw[p];
        end else begin
          par = par;
        end
      end
      cw[7'd1 << k] = par;
    end
    cw[0] = ^cw[71:1];
    return cw;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic; strobes outside IDLE are ignored.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:   next_state_s = send_packet ? S_DECODE : S_IDLE;
      S_DECODE: next_state_s = S_ENCODE;
      S_ENCODE: next_state_s = S_DONE;
      S_DONE:   next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // FSM control strobes for the datapath.
  always_comb begin
    capture_s = 1'b0;
    decode_s  = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      S_IDLE:   capture_s = send_packet;
      S_DECODE: decode_s  = 1'b1;
      S_ENCODE: finish_s  = 1'b1;
      S_DONE:   finish_s  = 1'b0;
      default:  finish_s  = 1'b0;
    endcase
  end

  // Packet field split and validation against the opcode rules.
  always_comb begin
    opcode_s  = pkt_r[7:0];
    target_s  = pkt_r[55:8];
    size_s    = pkt_r[63:56];
    payload_s = pkt_r[71:64];
    valid_s   = 1'b0;
    new_en_s  = encrypt_en_r;
    case (opcode_s)
      OP_ENCRYPT: begin
        valid_s  = (target_s == BROADCAST) && (size_s == 8'd1) && (payload_s[7:1] == 7'd0);
        new_en_s = payload_s[0];
      end
      OP_READ_YAW: begin
        valid_s = (size_s == 8'd0) && (target_s != BROADCAST) && (target_s != 48'd0);
      end
      default: valid_s = 1'b0;
    endcase
  end

  // Outbound frame; the encryption-config acknowledgement always goes out in clear.
  always_comb begin
    w0_s  = {seq_r, target_s, opcode_s};
    w1_s  = {47'd0, encrypt_en_r, payload_s, size_s};
    mix_s = {w1_s, w0_s[55:8]} ^ ENC_KEY;
    if (encrypt_en_r && (opcode_s != OP_ENCRYPT)) begin
      w1_s = mix_s[111:48];
      w0_s = {seq_r, mix_s[47:0], opcode_s};
    end else begin
      w1_s = w1_s;
    end
  end

  // Packet capture, validation result, encryption state and sequence counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_r        <= 72'd0;
      valid_r      <= 1'b0;
      encrypt_en_r <= 1'b0;
      seq_r        <= 8'd0;
    end else begin
      if (capture_s) pkt_r <= input_data[71:0];
      if (decode_s) begin
        valid_r <= valid_s;
        if (valid_s) encrypt_en_r <= new_en_s;
      end
      if (finish_s && valid_r) seq_r <= seq_r + 8'd1;
    end
  end

  // Registered outputs, updated as the FSM enters DONE and held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      encoded_output <= 144'd0;
      error          <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= finish_s;
      if (finish_s) begin
        encoded_output <= valid_r ? {secded_encode(w1_s), secded_encode(w0_s)} : 144'd0;
        error          <= ~valid_r;
      end
    end
  end

endmodule

// File: tb/tb_host_specific_top_rx_from_host.sv
// Directed testbench for host_specific_top_rx_from_host: drives command packets
// and checks frames by decoding the SECDED codewords back to expected words.
module tb_host_specific_top_rx_from_host;

  logic          clk;
  logic          reset;
  logic [1023:0] input_data;
  logic          send_packet;
  logic [143:0]  encoded_output;
  logic          error;
  logic          done;

  int checks_cnt;
  int errors_cnt;

  localparam logic [71:0] PKT_EN_ON  = 72'h0101FFFFFFFFFFFF01;
  localparam logic [71:0] PKT_EN_OFF = 72'h0001FFFFFFFFFFFF01;
  localparam logic [71:0] PKT_YAW    = 72'h00000000FF27FF27FF2703;
  localparam logic [71:0] PKT_BADOP  = 72'h00000000FF27FF27FF2705;
  localparam logic [71:0] PKT_BADTGT = 72'h0001FFFFFF27FFFF01;
  localparam logic [71:0] PKT_BADSZ  = 72'h0002FFFFFFFFFFFF01;
  localparam logic [71:0] PKT_TGT0   = 72'h000000000000000003;
  localparam logic [71:0] PKT_BADPL  = 72'h0201FFFFFFFFFFFF01;

  host_specific_top_rx_from_host dut (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .send_packet    (send_packet),
    .encoded_output (encoded_output),
    .error          (error),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pull the 64 data bits out of a codeword (positions 3..71 that are not powers of two).
  function automatic logic [63:0] extract(input logic [71:0] c);
    logic [63:0] d;
    logic [5:0]  j;
    d = 64'd0;
    j = 6'd0;
    for (logic [6:0] p = 7'd1; p < 7'd72; p++) begin
      if ((p & (p - 7'd1)) != 7'd0) begin
        d[j] = c[p];
        j    = j + 6'd1;
      end
    end
    return d;
  endfunction

  // {overall parity, 7-bit syndrome}: zero for a clean codeword.
  function automatic logic [7:0] syndrome(input logic [71:0] c);
    logic [6:0] s;
    s = 7'd0;
    for (logic [6:0] p = 7'd1; p < 7'd72; p++) begin
      if (c[p]) s = s ^ p;
    end
    return {^c, s};
  endfunction

  task automatic check_frame(input string tag, input logic [143:0] enc,
                             input logic [63:0] w0, input logic [63:0] w1);
    check_val({tag, "_syn0"}, {136'd0, syndrome(enc[71:0])}, 144'd0);
    check_val({tag, "_w0"}, {80'd0, extract(enc[71:0])}, {80'd0, w0});
    check_val({tag, "_syn1"}, {136'd0, syndrome(enc[143:72])}, 144'd0);
    check_val({tag, "_w1"}, {80'd0, extract(enc[143:72])}, {80'd0, w1});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic count_done(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) hits++;
    end
  endtask

  task automatic run_pkt(input logic [71:0] pkt, input string tag,
                         output logic [143:0] enc, output logic err);
    int n;
    @(negedge clk);
    input_data        = 1024'd0;
    input_data[71:0]  = pkt;
    send_packet       = 1'b1;
    @(posedge clk);
    #1;
    send_packet = 1'b0;
    wait_done(n);
    check_val({tag, "_lat"}, 144'(n), 144'd2);
    enc = encoded_output;
    err = error;
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, {143'd0, done}, 144'd0);
  endtask

  initial begin
    logic [143:0] enc;
    logic         err;
    logic [71:0]  cw;
    logic [71:0]  f;
    logic [7:0]   s;
    int           bad;
    int           n;
    int           hits;

    checks_cnt  = 0;
    errors_cnt  = 0;
    input_data  = 1024'd0;
    send_packet = 1'b0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out", {encoded_output, error, done}, 146'd0);
    @(negedge clk);
    reset = 1'b0;

    // T1: enable encryption; config ack is sent in clear with seq 0.
    run_pkt(PKT_EN_ON, "t1", enc, err);
    check_val("t1_err", {143'd0, err}, 144'd0);
    check_frame("t1", enc, 64'h00FFFFFFFFFFFF01, 64'h0000000000010101);

    // Any single-bit flip in a codeword must be located and corrected.
    for (int w = 0; w < 2; w++) begin
      cw  = (w == 0) ? enc[71:0] : enc[143:72];
      bad = 0;
      for (int b = 0; b < 72; b++) begin
        f = cw;
        f[b] = ~f[b];
        s = syndrome(f);
        if (s[6:0] != 7'd0) f[s[6:0]] = ~f[s[6:0]];
        else if (s[7]) f[0] = ~f[0];
        if (f !== cw || !s[7]) bad++;
      end
      check_val((w == 0) ? "flip_cw0" : "flip_cw1", 144'(bad), 144'd0);
    end

    // T2: disable encryption, seq 1.
    run_pkt(PKT_EN_OFF, "t2", enc, err);
    check_val("t2_err", {143'd0, err}, 144'd0);
    check_frame("t2", enc, 64'h01FFFFFFFFFFFF01, 64'h0000000000000001);

    // T3: read yaw in clear, seq 2.
    run_pkt(PKT_YAW, "t3", enc, err);
    check_val("t3_err", {143'd0, err}, 144'd0);
    check_frame("t3", enc, 64'h02FF27FF27FF2703, 64'h0000000000000000);

    // Re-enable encryption (seq 3), then read yaw encrypted (seq 4).
    run_pkt(PKT_EN_ON, "t3en", enc, err);
    check_frame("t3en", enc, 64'h03FFFFFFFFFFFF01, 64'h0000000000010101);
    run_pkt(PKT_YAW, "t3x", enc, err);
    check_val("t3x_err", {143'd0, err}, 144'd0);
    check_frame("t3x", enc, 64'h04A57DA57DA57D03, 64'h5A5A5A5A5A5B5A5A);

    // T4/T5 and other rejects: output zeroed, no state change.
    run_pkt(PKT_BADOP, "t4", enc, err);
    check_val("t4_err", {enc, err}, {144'd0, 1'b1});
    run_pkt(PKT_BADTGT, "t5t", enc, err);
    check_val("t5t_err", {enc, err}, {144'd0, 1'b1});
    run_pkt(PKT_BADSZ, "t5s", enc, err);
    check_val("t5s_err", {enc, err}, {144'd0, 1'b1});
    run_pkt(PKT_TGT0, "tgt0", enc, err);
    check_val("tgt0_err", {enc, err}, {144'd0, 1'b1});
    run_pkt(PKT_BADPL, "badpl", enc, err);
    check_val("badpl_err", {enc, err}, {144'd0, 1'b1});

    // Still encrypted, seq advanced only past valid packets: 5.
    run_pkt(PKT_YAW, "t5y", enc, err);
    check_val("t5y_err", {143'd0, err}, 144'd0);
    check_frame("t5y", enc, 64'h05A57DA57DA57D03, 64'h5A5A5A5A5A5B5A5A);

    // T6: a strobe while busy is ignored.
    @(negedge clk);
    input_data       = 1024'd0;
    input_data[71:0] = PKT_YAW;
    send_packet      = 1'b1;
    @(posedge clk);
    #1;
    send_packet = 1'b0;
    @(negedge clk);
    input_data[71:0] = PKT_BADOP;
    send_packet      = 1'b1;
    @(negedge clk);
    send_packet = 1'b0;
    wait_done(n);
    check_val("busy_done", {143'd0, done}, 144'd1);
    check_val("busy_err", {143'd0, error}, 144'd0);
    check_frame("busy", encoded_output, 64'h06A57DA57DA57D03, 64'h5A5A5A5A5A5B5A5A);
    count_done(8, hits);
    check_val("busy_extra", 144'(hits), 144'd0);
    run_pkt(PKT_YAW, "busy2", enc, err);
    check_frame("busy2", enc, 64'h07A57DA57DA57D03, 64'h5A5A5A5A5A5B5A5A);

    // T6: reset in the DECODE cycle clears everything and suppresses done.
    @(negedge clk);
    input_data[71:0] = PKT_YAW;
    send_packet      = 1'b1;
    @(posedge clk);
    #1;
    send_packet = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_mid_out", {encoded_output, error, done}, 146'd0);
    @(negedge clk);
    reset = 1'b0;
    count_done(8, hits);
    check_val("rst_mid_nodone", 144'(hits), 144'd0);

    // After reset: seq 0, encryption off.
    run_pkt(PKT_YAW, "post_rst", enc, err);
    check_frame("post_rst", enc, 64'h00FF27FF27FF2703, 64'h0000000000000000);

    // Sequence counter wraps 255 -> 0.
    for (int i = 1; i < 255; i++) begin
      run_pkt(PKT_YAW, "walk", enc, err);
    end
    run_pkt(PKT_YAW, "seq255", enc, err);
    check_frame("seq255", enc, 64'hFFFF27FF27FF2703, 64'h0000000000000000);
    run_pkt(PKT_YAW, "seqwrap", enc, err);
    check_frame("seqwrap", enc, 64'h00FF27FF27FF2703, 64'h0000000000000000);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
